// File: rtl/tlul_mtimer_pkg.sv
// Shared definitions for the TL-UL machine timer: register offsets, CTRL bit
// positions and the register-file struct.
package tlul_mtimer_pkg;

  localparam logic [4:0] MTIMER_CTRL_OFFSET        = 5'h00;
  localparam logic [4:0] MTIMER_PRESCALE_OFFSET    = 5'h04;
  localparam logic [4:0] MTIMER_MTIME_LO_OFFSET    = 5'h08;
  localparam logic [4:0] MTIMER_MTIME_HI_OFFSET    = 5'h0C;
  localparam logic [4:0] MTIMER_MTIMECMP_LO_OFFSET = 5'h10;
  localparam logic [4:0] MTIMER_MTIMECMP_HI_OFFSET = 5'h14;
  localparam logic [4:0] MTIMER_STATUS_OFFSET      = 5'h18;
  localparam logic [4:0] MTIMER_UNMAPPED_OFFSET    = 5'h1C;

  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;

  typedef struct packed {
    logic        ctrl_enable;
    logic        ctrl_irq_en;
    logic [31:0] prescale;
    logic [63:0] mtime;
    logic [63:0] mtimecmp;
  } mtimer_reg_t;

  localparam mtimer_reg_t MTIMER_REG_RESET = '{
    ctrl_enable: 1'b0,
    ctrl_irq_en: 1'b0,
    prescale:    32'h0,
    mtime:       64'h0,
    mtimecmp:    {64{1'b1}}
  };

  // Word-aligned and not the hole at 0x1C.
  function automatic logic mtimer_offset_ok(input logic [4:0] off);
    return (off[1:0] == 2'b00) && (off != MTIMER_UNMAPPED_OFFSET);
  endfunction

endpackage

// File: rtl/tlul_pkg.sv
// Minimal TL-UL type package: channel structs, opcodes and the 7-bit integrity
// code shared by the response integrity generator.
package tlul_pkg;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic [6:0] cmd_intg;
    logic [6:0] data_intg;
  } tl_a_user_t;

  typedef struct packed {
    logic [6:0] rsp_intg;
    logic [6:0] data_intg;
  } tl_d_user_t;

  typedef struct packed {
    logic        a_valid;
    tl_a_op_e    a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    tl_a_user_t  a_user;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    tl_d_op_e    d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    tl_d_user_t  d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

  // Hamming-style check bits: bit k covers every position whose (index+1) has bit k set.
  function automatic logic [6:0] tl_intg7(input logic [63:0] d);
    logic [6:0] c;
    c = '0;
    for (int i = 0; i < 64; i++) begin
      for (int k = 0; k < 7; k++) begin
        if ((((i + 1) >> k) & 1) != 0) c[k] = c[k] ^ d[i];
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/tlul_mtimer_core.sv
// Timer datapath: prescaler, 64-bit mtime counter, mtimecmp compare and the
// registered interrupt. Driven by decoded register write strobes.
module tlul_mtimer_core
  import tlul_mtimer_pkg::*;
#(
  parameter int PrescaleW = 12
) (
  input  logic        i_clk,
  input  logic        i_srst,
  input  logic        i_wr_ctrl,
  input  logic        i_wr_prescale,
  input  logic        i_wr_mtime_lo,
  input  logic        i_wr_mtime_hi,
  input  logic        i_wr_cmp_lo,
  input  logic        i_wr_cmp_hi,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_wmask,
  output mtimer_reg_t o_regs,
  output logic        o_expired,
  output logic        o_irq
);

  localparam logic [31:0] PrescMask = 32'((64'd1 << PrescaleW) - 64'd1);

  mtimer_reg_t          r_regs;
  logic [PrescaleW-1:0] r_presc_cnt;
  logic                 r_irq;

  logic [31:0] w_bitmask;
  logic        w_tick;
  logic        w_expired;
  logic        w_mtime_wr;

  for (genvar gi = 0; gi < 4; gi++) begin : g_bytemask
    assign w_bitmask[gi*8 +: 8] = {8{i_wmask[gi]}};
  end

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [31:0] bm);
    return (old_v & ~bm) | (new_v & bm);
  endfunction

  assign w_tick     = r_regs.ctrl_enable && (32'(r_presc_cnt) == r_regs.prescale);
  assign w_expired  = r_regs.mtime >= r_regs.mtimecmp;
  assign w_mtime_wr = i_wr_mtime_lo || i_wr_mtime_hi;

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_regs      <= MTIMER_REG_RESET;
      r_presc_cnt <= '0;
      r_irq       <= 1'b0;
    end else begin
      if (i_wr_ctrl || i_wr_prescale || w_tick) begin
        r_presc_cnt <= '0;
      end else if (r_regs.ctrl_enable) begin
        r_presc_cnt <= r_presc_cnt + PrescaleW'(1);
      end

      if (i_wr_ctrl && i_wmask[0]) begin
        r_regs.ctrl_enable <= i_wdata[CTRL_ENABLE_BIT];
        r_regs.ctrl_irq_en <= i_wdata[CTRL_IRQ_EN_BIT];
      end
      if (i_wr_prescale) begin
        r_regs.prescale <= merge(r_regs.prescale, i_wdata, w_bitmask) & PrescMask;
      end

      // A software write to either half swallows a coincident tick.
      if (w_mtime_wr) begin
        if (i_wr_mtime_lo) r_regs.mtime[31:0]  <= merge(r_regs.mtime[31:0], i_wdata, w_bitmask);
        if (i_wr_mtime_hi) r_regs.mtime[63:32] <= merge(r_regs.mtime[63:32], i_wdata, w_bitmask);
      end else if (w_tick) begin
        r_regs.mtime <= r_regs.mtime + 64'd1;
      end

      if (i_wr_cmp_lo) r_regs.mtimecmp[31:0]  <= merge(r_regs.mtimecmp[31:0], i_wdata, w_bitmask);
      if (i_wr_cmp_hi) r_regs.mtimecmp[63:32] <= merge(r_regs.mtimecmp[63:32], i_wdata, w_bitmask);

      r_irq <= r_regs.ctrl_irq_en && w_expired;
    end
  end

  assign o_regs    = r_regs;
  assign o_expired = w_expired;
  assign o_irq     = r_irq;

endmodule

// File: rtl/tlul_rsp_intg_gen.sv
// Response integrity generator: fills d_user with check bits over the response
// header and the data word.
module tlul_rsp_intg_gen
  import tlul_pkg::*;
(
  input  tl_d2h_t tl_i,
  output tl_d2h_t tl_o
);

  logic [63:0] w_hdr;

  assign w_hdr = {50'b0, tl_i.d_opcode, tl_i.d_size, tl_i.d_error, tl_i.d_source};

  always_comb begin
    tl_o                  = tl_i;
    tl_o.d_user.rsp_intg  = tl_intg7(w_hdr);
    tl_o.d_user.data_intg = tl_intg7({32'b0, tl_i.d_data});
  end

endmodule

// File: rtl/tlul_mtimer.sv
// TL-UL machine timer device: request decode, error checking, register readback
// with the mtime high-word shadow, and the single-entry response register.
module tlul_mtimer
  import tlul_pkg::*;
  import tlul_mtimer_pkg::*;
#(
  parameter int PrescaleW        = 12,
  parameter bit EnableRspIntgGen = 1'b1
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  tl_h2d_t tl_i,
  output tl_d2h_t tl_o,
  output logic    irq_timer_o
);

  logic        r_d_valid;
  tl_d_op_e    r_d_opcode;
  logic [1:0]  r_d_size;
  logic [7:0]  r_d_source;
  logic [31:0] r_d_data;
  logic        r_d_error;
  logic [31:0] r_mtime_shadow;

  logic [4:0]  w_off;
  logic        w_is_get;
  logic        w_is_put;
  logic        w_err;
  logic        w_a_ready;
  logic        w_accept;
  logic        w_wr;
  logic        w_rd;
  logic [31:0] w_rdata;
  mtimer_reg_t w_regs;
  logic        w_expired;
  logic        w_irq;
  tl_d2h_t     w_tl_raw;
  logic        w_unused;

  assign w_unused = ^{tl_i.a_param, tl_i.a_user, tl_i.a_address[31:5]};

  assign w_off    = tl_i.a_address[4:0];
  assign w_is_get = (tl_i.a_opcode == Get);
  assign w_is_put = (tl_i.a_opcode == PutFullData) || (tl_i.a_opcode == PutPartialData);
  assign w_err    = !mtimer_offset_ok(w_off)
                 || (tl_i.a_size != 2'd2)
                 || !(w_is_get || w_is_put)
                 || ((tl_i.a_opcode == PutFullData) && (tl_i.a_mask != 4'hF));

  assign w_a_ready = !r_d_valid || tl_i.d_ready;
  assign w_accept  = tl_i.a_valid && w_a_ready;
  assign w_wr      = w_accept && w_is_put && !w_err;
  assign w_rd      = w_accept && w_is_get && !w_err;

  tlul_mtimer_core #(
    .PrescaleW(PrescaleW)
  ) u_core (
    .i_clk        (clk_i),
    .i_srst       (rst_i),
    .i_wr_ctrl    (w_wr && (w_off == MTIMER_CTRL_OFFSET)),
    .i_wr_prescale(w_wr && (w_off == MTIMER_PRESCALE_OFFSET)),
    .i_wr_mtime_lo(w_wr && (w_off == MTIMER_MTIME_LO_OFFSET)),
    .i_wr_mtime_hi(w_wr && (w_off == MTIMER_MTIME_HI_OFFSET)),
    .i_wr_cmp_lo  (w_wr && (w_off == MTIMER_MTIMECMP_LO_OFFSET)),
    .i_wr_cmp_hi  (w_wr && (w_off == MTIMER_MTIMECMP_HI_OFFSET)),
    .i_wdata      (tl_i.a_data),
    .i_wmask      (tl_i.a_mask),
    .o_regs       (w_regs),
    .o_expired    (w_expired),
    .o_irq        (w_irq)
  );

  always_comb begin
    w_rdata = '0;
    if (!w_err) begin
      unique case (w_off)
        MTIMER_CTRL_OFFSET:        w_rdata = {30'b0, w_regs.ctrl_irq_en, w_regs.ctrl_enable};
        MTIMER_PRESCALE_OFFSET:    w_rdata = w_regs.prescale;
        MTIMER_MTIME_LO_OFFSET:    w_rdata = w_regs.mtime[31:0];
        MTIMER_MTIME_HI_OFFSET:    w_rdata = r_mtime_shadow;
        MTIMER_MTIMECMP_LO_OFFSET: w_rdata = w_regs.mtimecmp[31:0];
        MTIMER_MTIMECMP_HI_OFFSET: w_rdata = w_regs.mtimecmp[63:32];
        MTIMER_STATUS_OFFSET:      w_rdata = {31'b0, w_expired};
        default:                   w_rdata = '0;
      endcase
    end
  end

  // Reading LO freezes the high word so the following HI read is coherent.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mtime_shadow <= '0;
    end else if (w_rd && (w_off == MTIMER_MTIME_LO_OFFSET)) begin
      r_mtime_shadow <= w_regs.mtime[63:32];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_d_valid  <= 1'b0;
      r_d_opcode <= AccessAck;
      r_d_size   <= '0;
      r_d_source <= '0;
      r_d_data   <= '0;
      r_d_error  <= 1'b0;
    end else if (w_accept) begin
      r_d_valid  <= 1'b1;
      r_d_opcode <= w_is_get ? AccessAckData : AccessAck;
      r_d_size   <= tl_i.a_size;
      r_d_source <= tl_i.a_source;
      r_d_data   <= w_is_get ? w_rdata : 32'h0;
      r_d_error  <= w_err;
    end else if (tl_i.d_ready) begin
      r_d_valid  <= 1'b0;
    end
  end

  always_comb begin
    w_tl_raw          = '0;
    w_tl_raw.d_valid  = r_d_valid;
    w_tl_raw.d_opcode = r_d_opcode;
    w_tl_raw.d_size   = r_d_size;
    w_tl_raw.d_source = r_d_source;
    w_tl_raw.d_data   = r_d_data;
    w_tl_raw.d_error  = r_d_error;
    w_tl_raw.a_ready  = w_a_ready;
  end

  if (EnableRspIntgGen) begin : g_intg
    tlul_rsp_intg_gen u_rsp_intg (
      .tl_i(w_tl_raw),
      .tl_o(tl_o)
    );
  end else begin : g_no_intg
    assign tl_o = w_tl_raw;
  end

  assign irq_timer_o = w_irq;

endmodule

// File: tb/tb_tlul_mtimer.sv
// Directed bench for tlul_mtimer: register access, prescaled counting, coherent
// 64-bit reads, interrupt timing, error responses and response back-pressure.
module tb_tlul_mtimer;
  import tlul_pkg::*;

  logic    clk;
  logic    rst;
  tl_h2d_t tl_h;
  tl_d2h_t tl_d;
  logic    irq;

  int         n_cmp;
  int         n_bad;
  logic [7:0] src_q;

  tlul_mtimer #(
    .PrescaleW       (12),
    .EnableRspIntgGen(1'b1)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .tl_i       (tl_h),
    .tl_o       (tl_d),
    .irq_timer_o(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 400000");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic rst_pulse();
    rst  = 1'b1;
    tl_h = '0;
    tl_h.d_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic tl_xfer(input logic [2:0] op, input logic [31:0] addr, input logic [1:0] size,
                         input logic [3:0] mask, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err);
    int waited;
    logic [7:0] src;
    src = src_q;
    src_q++;
    @(negedge clk);
    tl_h.a_valid   = 1'b1;
    tl_h.a_opcode  = tl_a_op_e'(op);
    tl_h.a_address = addr;
    tl_h.a_size    = size;
    tl_h.a_mask    = mask;
    tl_h.a_data    = wdata;
    tl_h.a_source  = src;
    tl_h.d_ready   = 1'b1;
    waited = 0;
    while (!tl_d.a_ready && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (!tl_d.a_ready) check_val("a_ready_wait", tl_d.a_ready, 1);
    @(posedge clk);
    #1 tl_h.a_valid = 1'b0;
    @(negedge clk);
    waited = 0;
    while (!tl_d.d_valid && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (!tl_d.d_valid) check_val("d_valid_wait", tl_d.d_valid, 1);
    rdata = tl_d.d_data;
    err   = tl_d.d_error;
    check_val("d_source", tl_d.d_source, src);
    check_val("d_size", tl_d.d_size, size);
    check_val("d_opcode", tl_d.d_opcode, (op == 3'd4) ? 64'd1 : 64'd0);
    $display("xfer op=%0d addr=%h size=%0d mask=%h wdata=%h -> rdata=%h err=%0d",
             op, addr, size, mask, wdata, rdata, err);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] d;
    logic        e;
    tl_xfer(3'd0, addr, 2'd2, 4'hF, data, d, e);
    check_val("wr_err", e, 0);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    logic        e;
    tl_xfer(3'd4, addr, 2'd2, 4'hF, 32'h0, d, e);
    check_val(tag, d, exp);
    check_val({tag, "_err"}, e, 0);
  endtask

  task automatic bad_chk(input string tag, input logic [2:0] op, input logic [31:0] addr,
                         input logic [1:0] size, input logic [3:0] mask, input logic [31:0] wdata);
    logic [31:0] d;
    logic        e;
    tl_xfer(op, addr, size, mask, wdata, d, e);
    check_val({tag, "_err"}, e, 1);
    check_val({tag, "_data"}, d, 0);
  endtask

  initial begin
    logic [31:0] d;
    logic        e;
    n_cmp = 0;
    n_bad = 0;
    src_q = 8'h10;

    // 1: reset values and mtimecmp readback
    rst_pulse();
    @(negedge clk);
    check_val("rst_d_valid", tl_d.d_valid, 0);
    check_val("rst_a_ready", tl_d.a_ready, 1);
    check_val("rst_irq", irq, 0);
    check_val("rst_d_data", tl_d.d_data, 0);
    rd_chk("cmp_lo_rst", 32'h10, 32'hFFFF_FFFF);
    rd_chk("cmp_hi_rst", 32'h14, 32'hFFFF_FFFF);
    rd_chk("ctrl_rst", 32'h00, 32'h0);
    check_val("irq_idle", irq, 0);

    // 2: prescale 3 gives one tick per 4 cycles; prescale 0 one per cycle
    rst_pulse();
    wr(32'h04, 32'd3);
    wr(32'h00, 32'd1);
    repeat (40) @(posedge clk);
    rd_chk("mtime_presc3", 32'h08, 32'd10);
    wr(32'h04, 32'd0);
    rd_chk("mtime_presc0_a", 32'h08, 32'd11);
    rd_chk("mtime_presc0_b", 32'h08, 32'd13);

    // 3: coherent LO/HI read across the 32-bit carry
    rst_pulse();
    wr(32'h0C, 32'h0);
    wr(32'h08, 32'hFFFF_FFFE);
    wr(32'h00, 32'd1);
    rd_chk("carry_lo1", 32'h08, 32'hFFFF_FFFF);
    rd_chk("carry_hi1", 32'h0C, 32'h0);
    rd_chk("carry_lo2", 32'h08, 32'h3);
    rd_chk("carry_hi2", 32'h0C, 32'h1);

    // 4: interrupt rises one cycle after mtime reaches 20, drops on cmp rewrite
    rst_pulse();
    wr(32'h10, 32'd20);
    wr(32'h14, 32'd0);
    wr(32'h00, 32'd3);
    repeat (19) @(negedge clk);
    check_val("irq_mtime19", irq, 0);
    @(negedge clk);
    check_val("irq_mtime20", irq, 0);
    @(negedge clk);
    check_val("irq_rise", irq, 1);
    wr(32'h14, 32'd1);
    check_val("irq_before_drop", irq, 1);
    @(negedge clk);
    check_val("irq_drop", irq, 0);
    rd_chk("status_clear", 32'h18, 32'h0);
    wr(32'h14, 32'd0);
    rd_chk("status_set", 32'h18, 32'h1);
    wr(32'h00, 32'd1);
    @(negedge clk);
    check_val("irq_en_off", irq, 0);

    // 5: partial writes and illegal accesses
    rst_pulse();
    tl_xfer(3'd1, 32'h04, 2'd2, 4'h2, 32'hABCD_5A00, d, e);
    check_val("ppart1_err", e, 0);
    rd_chk("presc_ppart1", 32'h04, 32'h0000_0A00);
    tl_xfer(3'd1, 32'h04, 2'd2, 4'h1, 32'h0000_0077, d, e);
    check_val("ppart2_err", e, 0);
    rd_chk("presc_ppart2", 32'h04, 32'h0000_0A77);
    bad_chk("pfull_mask3", 3'd0, 32'h04, 2'd2, 4'h3, 32'h0000_0123);
    rd_chk("presc_kept", 32'h04, 32'h0000_0A77);
    bad_chk("misaligned", 3'd0, 32'h02, 2'd2, 4'hF, 32'h3);
    rd_chk("ctrl_kept1", 32'h00, 32'h0);
    bad_chk("unmapped", 3'd4, 32'h1C, 2'd2, 4'hF, 32'h0);
    bad_chk("size1_get", 3'd4, 32'h10, 2'd1, 4'hF, 32'h0);
    bad_chk("size1_put", 3'd0, 32'h10, 2'd1, 4'hF, 32'h0);
    rd_chk("cmp_kept", 32'h10, 32'hFFFF_FFFF);
    bad_chk("bad_opcode", 3'd2, 32'h00, 2'd2, 4'hF, 32'h3);
    rd_chk("ctrl_kept2", 32'h00, 32'h0);
    wr(32'h18, 32'h1);
    rd_chk("status_ro", 32'h18, 32'h0);
    rd_chk("upper_addr", 32'h1000_0010, 32'hFFFF_FFFF);

    // 6: back-pressure with a second request waiting
    rst_pulse();
    wr(32'h10, 32'h1234_5678);
    @(negedge clk);
    tl_h.d_ready   = 1'b0;
    tl_h.a_valid   = 1'b1;
    tl_h.a_opcode  = Get;
    tl_h.a_address = 32'h10;
    tl_h.a_size    = 2'd2;
    tl_h.a_mask    = 4'hF;
    tl_h.a_source  = 8'h21;
    @(posedge clk);
    #1;
    tl_h.a_address = 32'h14;
    tl_h.a_source  = 8'h22;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("bp_a_ready", tl_d.a_ready, 0);
      check_val("bp_d_valid", tl_d.d_valid, 1);
      check_val("bp_d_data", tl_d.d_data, 32'h1234_5678);
      check_val("bp_d_source", tl_d.d_source, 8'h21);
    end
    $display("xfer backpressure first response held 5 cycles data=%h", tl_d.d_data);
    tl_h.d_ready = 1'b1;
    @(posedge clk);
    #1 tl_h.a_valid = 1'b0;
    @(negedge clk);
    check_val("bp2_d_valid", tl_d.d_valid, 1);
    check_val("bp2_d_data", tl_d.d_data, 32'hFFFF_FFFF);
    check_val("bp2_d_source", tl_d.d_source, 8'h22);
    $display("xfer backpressure second response data=%h src=%h", tl_d.d_data, tl_d.d_source);
    @(negedge clk);
    check_val("bp_drained", tl_d.d_valid, 0);

    // reset while a response is pending drops it
    tl_h.d_ready  = 1'b0;
    tl_h.a_valid  = 1'b1;
    tl_h.a_source = 8'h33;
    @(posedge clk);
    #1 tl_h.a_valid = 1'b0;
    @(negedge clk);
    check_val("pend_d_valid", tl_d.d_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    check_val("rst_drop_d_valid", tl_d.d_valid, 0);
    check_val("rst_drop_a_ready", tl_d.a_ready, 1);
    rst = 1'b0;
    tl_h.d_ready = 1'b1;
    rd_chk("cmp_lo_after_rst", 32'h10, 32'hFFFF_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
